// File: rtl/pl_register_file_if.sv
// Bus bundle for pl_register_file: two read ports, one write-back port, the issue port and ready.
// master = ID/WB side driving addresses and strobes, slave = register file.
interface pl_register_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;
  logic             busy1;
  logic             busy2;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             ready;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rd1_data, rd2_data, busy1, busy2, ready
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rd1_data, rd2_data, busy1, busy2, ready
  );
endinterface

// File: rtl/pl_register_file.sv
// 2R/1W register file with write-to-read bypass, pending-write scoreboard and post-reset clear.
// Optional: define PL_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module pl_register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  pl_register_file_if.slave  rf
);
  localparam int AW = $clog2(DEPTH);

`ifdef PL_REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [DEPTH-1:0][WIDTH-1:0]  regs_q, regs_d;

  logic run;
  logic wr_ok, issue_ok;

  assign run      = (state_q == S_RUN);
  assign wr_ok    = rf.wr_en    && !(ZERO_REG && rf.wr_addr  == '0);
  assign issue_ok = rf.issue_en && !(ZERO_REG && rf.issue_rd == '0);

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    busy_d     = busy_q;
    regs_d     = regs_q;
    case (state_q)
      S_INIT: begin
        regs_d[init_ptr_q] = '0;
        init_ptr_d         = init_ptr_q + 1'b1;
        if (init_ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
      end
      default: begin
        if (wr_ok) begin
          regs_d[rf.wr_addr] = rf.wr_data;
          busy_d[rf.wr_addr] = 1'b0;
        end
        // issue applied after the write so a same-address pair leaves the bit set
        if (issue_ok) busy_d[rf.issue_rd] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      busy_q     <= busy_d;
    end
  end

  // storage is cleared by the init sequence rather than by reset
  always_ff @(posedge clk) regs_q <= regs_d;

  logic             hit1, hit2, zero1, zero2;
  logic [WIDTH-1:0] rd1, rd2;
  logic             bsy1, bsy2;

  assign hit1  = rf.wr_en && (rf.wr_addr == rf.rs1_addr);
  assign hit2  = rf.wr_en && (rf.wr_addr == rf.rs2_addr);
  assign zero1 = ZERO_REG && (rf.rs1_addr == '0);
  assign zero2 = ZERO_REG && (rf.rs2_addr == '0);

  always_comb begin
    rd1  = '0;
    rd2  = '0;
    bsy1 = 1'b0;
    bsy2 = 1'b0;
    if (run && !zero1) begin
      rd1  = hit1 ? rf.wr_data : regs_q[rf.rs1_addr];
      bsy1 = busy_q[rf.rs1_addr] && !hit1;
    end
    if (run && !zero2) begin
      rd2  = hit2 ? rf.wr_data : regs_q[rf.rs2_addr];
      bsy2 = busy_q[rf.rs2_addr] && !hit2;
    end
  end

  assign rf.rd1_data = rd1;
  assign rf.rd2_data = rd2;
  assign rf.busy1    = bsy1;
  assign rf.busy2    = bsy2;
  assign rf.ready    = run;
endmodule

// File: tb/tb_pl_register_file.sv
// Randomized bench for pl_register_file against an array-based model, plus directed scenarios.
module tb_pl_register_file;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = $clog2(D);
`ifdef PL_REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pl_register_file_if #(.WIDTH(W), .DEPTH(D)) rf ();

  pl_register_file #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] m_regs [D];
  bit           m_busy [D];
  int           m_cnt = 0;

  function automatic bit m_ready();
    return m_cnt >= D;
  endfunction

  function automatic logic [W-1:0] exp_rd(logic [AW-1:0] a);
    if (!m_ready() || (ZR && a == 0)) return '0;
    if (rf.wr_en && rf.wr_addr == a) return rf.wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    if (!m_ready() || (ZR && a == 0)) return 1'b0;
    return m_busy[a] && !(rf.wr_en && rf.wr_addr == a);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("rd1",   32'(rf.rd1_data), 32'(exp_rd(rf.rs1_addr)));
    chk("rd2",   32'(rf.rd2_data), 32'(exp_rd(rf.rs2_addr)));
    chk("busy1", 32'(rf.busy1),    32'(exp_busy(rf.rs1_addr)));
    chk("busy2", 32'(rf.busy2),    32'(exp_busy(rf.rs2_addr)));
    chk("ready", 32'(rf.ready),    32'(m_ready()));
  endtask

  // inputs are set at negedge; outputs checked, then model advanced at posedge
  task automatic cycle();
    #1 check_outs();
    @(posedge clk);
    if (!reset) begin
      if (!m_ready()) begin
        m_cnt++;
        if (m_cnt == D) foreach (m_regs[i]) m_regs[i] = '0;
      end else begin
        if (rf.wr_en && !(ZR && rf.wr_addr == 0)) begin
          m_regs[rf.wr_addr] = rf.wr_data;
          m_busy[rf.wr_addr] = 1'b0;
        end
        if (rf.issue_en && !(ZR && rf.issue_rd == 0)) m_busy[rf.issue_rd] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rf.wr_en    = 1'b0;
    rf.issue_en = 1'b0;
    rf.wr_addr  = '0;
    rf.wr_data  = '0;
    rf.issue_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_cnt = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    idle();
    rf.rs1_addr = '0;
    rf.rs2_addr = '0;
    @(negedge clk);
    do_reset();

    // T1: ready low for D cycles, reads zero; writes during init ignored
    for (int i = 0; i < D + 2; i++) begin
      rf.rs1_addr = AW'($urandom_range(D - 1));
      rf.rs2_addr = AW'($urandom_range(D - 1));
      rf.wr_en    = 1'b1;
      rf.wr_addr  = rf.rs1_addr;
      rf.wr_data  = 8'hEE;
      #1 chk("t1_ready", 32'(rf.ready), 32'(i >= D));
      cycle();
    end
    idle();

    // T2: write then read
    rf.wr_en = 1'b1; rf.wr_addr = 3; rf.wr_data = 8'hA5;
    cycle();
    idle(); rf.rs1_addr = 3;
    #1 chk("t2_rd1", 32'(rf.rd1_data), 32'h A5);
    chk("t2_busy1", 32'(rf.busy1), 32'h0);
    cycle();

    // T3: same-cycle bypass
    rf.wr_en = 1'b1; rf.wr_addr = 5; rf.wr_data = 8'h3C; rf.rs2_addr = 5;
    #1 chk("t3_rd2", 32'(rf.rd2_data), 32'h3C);
    cycle();
    idle();

    // T4: issue sets busy, write-back clears it with bypass
    rf.issue_en = 1'b1; rf.issue_rd = 2;
    cycle();
    idle(); rf.rs1_addr = 2;
    #1 chk("t4_busy_set", 32'(rf.busy1), 32'h1);
    rf.wr_en = 1'b1; rf.wr_addr = 2; rf.wr_data = 8'h11;
    #1 chk("t4_busy_byp", 32'(rf.busy1), 32'h0);
    chk("t4_rd1", 32'(rf.rd1_data), 32'h11);
    cycle();
    idle();

    // T5: same-cycle issue and write, issue wins
    rf.issue_en = 1'b1; rf.issue_rd = 4;
    rf.wr_en = 1'b1; rf.wr_addr = 4; rf.wr_data = 8'h77;
    cycle();
    idle(); rf.rs1_addr = 4; rf.rs2_addr = 4;
    #1 chk("t5_rd1", 32'(rf.rd1_data), 32'h77);
    chk("t5_busy1", 32'(rf.busy1), 32'h1);
    chk("t5_busy2", 32'(rf.busy2), 32'h1);
    cycle();

    // T6: reset in the middle of init restarts the full sequence
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    do_reset();
    for (int i = 0; i < D + 2; i++) begin
      #1 chk("t6_ready", 32'(rf.ready), 32'(i >= D));
      cycle();
    end
    rf.wr_en = 1'b1; rf.wr_addr = 0; rf.wr_data = 8'hFF;
    rf.issue_en = 1'b1; rf.issue_rd = 0; rf.rs1_addr = 0;
    #1 chk("t6_r0_byp", 32'(rf.rd1_data), ZR ? 32'h0 : 32'hFF);
    cycle();
    idle(); rf.rs1_addr = 0;
    #1 chk("t6_r0_rd", 32'(rf.rd1_data), ZR ? 32'h0 : 32'hFF);
    chk("t6_r0_busy", 32'(rf.busy1), ZR ? 32'h0 : 32'h1);
    cycle();

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(149) == 0) begin
        idle();
        do_reset();
      end else begin
        rf.rs1_addr = AW'($urandom_range(D - 1));
        rf.rs2_addr = ($urandom_range(3) == 0) ? rf.rs1_addr : AW'($urandom_range(D - 1));
        rf.wr_en    = ($urandom_range(1) == 1);
        rf.wr_addr  = AW'($urandom_range(D - 1));
        rf.wr_data  = W'($urandom);
        rf.issue_en = ($urandom_range(9) < 3);
        rf.issue_rd = AW'($urandom_range(D - 1));
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
